signal_phase_scheduler: RTL and testbench

- Right-of-way scheduler for a 4-approach intersection; the next step beyond the 2-road main/side controller.
- Shares the green phase between four approach sensors and a pedestrian walk phase, round-robin.
- Enforces min/max green, yellow and all-red clearance, and gives absolute priority to an emergency preempt.
- Timing is driven by an external 1-second tick pulse; the block itself does not divide the clock.

---
 rtl/signal_phase_scheduler_if.sv | 22 ++
 rtl/signal_phase_scheduler.sv | 171 +++++++++++++++++
 tb/tb_signal_phase_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/signal_phase_scheduler_if.sv
// Intersection scheduler I/O bundle: tick, sensors and preempt in; lamp drive out.
interface signal_phase_scheduler_if;
  logic       tick;
  logic [3:0] req;
  logic       walk_req;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [7:0] light;
  logic       walk;
  logic [1:0] cur_dir;
  logic [1:0] state_o;

  modport master (
    output tick, req, walk_req, preempt, preempt_dir,
    input  light, walk, cur_dir, state_o
  );

  modport slave (
    input  tick, req, walk_req, preempt, preempt_dir,
    output light, walk, cur_dir, state_o
  );
endinterface

// File: rtl/signal_phase_scheduler.sv
// Round-robin right-of-way scheduler for a 4-approach intersection with walk phase
// and emergency preempt; all timing counts external 1-second ticks.

module approach_lamp (
  input  logic [1:0] phase,
  input  logic       own,
  output logic [1:0] lamp
);
  // Only the owning approach can be non-red, and only in GREEN/YELLOW.
  always_comb begin
    lamp = 2'b10;
    if (own && phase == 2'b00) lamp = 2'b00;
    if (own && phase == 2'b01) lamp = 2'b01;
  end
endmodule

module signal_phase_scheduler #(
  parameter int MIN_GREEN = 6,
  parameter int MAX_GREEN = 12,
  parameter int YEL_T     = 2,
  parameter int RED_T     = 1,
  parameter int WALK_T    = 3,
  parameter int TW        = 8
) (
  input logic clk,
  input logic reset,
  signal_phase_scheduler_if.slave bus
);
  localparam int NUM_APP = 4;
  localparam logic [TW:0]   MIN_G     = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   MAX_G     = (TW+1)'(MAX_GREEN);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YEL_T - 1);
  localparam logic [TW-1:0] RED_LAST  = TW'(RED_T - 1);
  localparam logic [TW-1:0] WALK_LAST = TW'(WALK_T - 1);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10,
    WALK    = 2'b11
  } phase_t;

  phase_t        state, stateNxt;
  logic [1:0]    curDir, dirNxt;
  logic [TW-1:0] timer, timerNxt;
  logic [TW:0]   timerP1;
  logic          walkPend, walkPendNxt;
  logic          lastWasWalk, lastWasWalkNxt;
  logic [7:0]    lightQ;
  logic          walkQ;

  logic [NUM_APP-1:0]      dirOh;
  logic                    other;
  logic                    reqAny;
  logic [1:0]              rrDir;
  logic [1:0]              probe;
  logic                    found;
  logic                    entry;
  logic [NUM_APP-1:0][1:0] lightNxt;

  assign timerP1 = {1'b0, timer} + 1'b1;
  assign dirOh   = 4'b0001 << curDir;
  assign other   = (|(bus.req & ~dirOh)) | walkPend;
  assign reqAny  = |bus.req;

  // Round-robin search starting just past the current owner, ending on it.
  always_comb begin
    rrDir = 2'd0;
    found = 1'b0;
    probe = 2'd0;
    for (int k = 1; k <= NUM_APP; k++) begin
      probe = curDir + 2'(k);
      if (!found && bus.req[probe]) begin
        found = 1'b1;
        rrDir = probe;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    dirNxt   = curDir;
    case (state)
      GREEN: begin
        if (bus.preempt) begin
          if (bus.preempt_dir != curDir) stateNxt = YELLOW;
        end else if (bus.tick && timerP1 >= MIN_G && other &&
                     (!bus.req[curDir] || timerP1 >= MAX_G)) begin
          stateNxt = YELLOW;
        end
      end
      YELLOW: begin
        if (bus.tick && timer == YEL_LAST) stateNxt = ALL_RED;
      end
      ALL_RED: begin
        if (bus.tick && timer == RED_LAST) begin
          if (bus.preempt) begin
            stateNxt = GREEN;
            dirNxt   = bus.preempt_dir;
          end else if (walkPend && !lastWasWalk) begin
            stateNxt = WALK;
          end else begin
            stateNxt = GREEN;
            dirNxt   = reqAny ? rrDir : 2'd0;
          end
        end
      end
      WALK: begin
        // Preempt cuts the walk short; clearance that follows is never shortened.
        if (bus.preempt || (bus.tick && timer == WALK_LAST)) stateNxt = ALL_RED;
      end
      default: stateNxt = GREEN;
    endcase
  end

  assign entry = (stateNxt != state);

  always_comb begin
    timerNxt = timer;
    if (entry)                        timerNxt = '0;
    else if (bus.tick && timer != '1) timerNxt = timer + 1'b1;
  end

  always_comb begin
    walkPendNxt    = walkPend;
    lastWasWalkNxt = lastWasWalk;
    if (entry && stateNxt == WALK) begin
      walkPendNxt    = 1'b0;
      lastWasWalkNxt = 1'b1;
    end else if (bus.walk_req && state != WALK) begin
      walkPendNxt = 1'b1;
    end
    if (entry && stateNxt == GREEN) lastWasWalkNxt = 1'b0;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_APP; i++) begin : gLamp
      approach_lamp uLamp (
        .phase (stateNxt),
        .own   (dirNxt == 2'(i)),
        .lamp  (lightNxt[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= GREEN;
      curDir      <= 2'd0;
      timer       <= '0;
      walkPend    <= 1'b0;
      lastWasWalk <= 1'b0;
      lightQ      <= 8'b10101000;
      walkQ       <= 1'b0;
    end else begin
      state       <= stateNxt;
      curDir      <= dirNxt;
      timer       <= timerNxt;
      walkPend    <= walkPendNxt;
      lastWasWalk <= lastWasWalkNxt;
      lightQ      <= lightNxt;
      walkQ       <= (stateNxt == WALK);
    end
  end

  assign bus.light   = lightQ;
  assign bus.walk    = walkQ;
  assign bus.cur_dir = curDir;
  assign bus.state_o = state;
endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed scenarios for signal_phase_scheduler; expectations queued per step, checked after the DUT edge.
module tb_signal_phase_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  signal_phase_scheduler_if bus();

  signal_phase_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, W = 2'b11;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] lightOf(logic [1:0] st, logic [1:0] d);
    logic [7:0] l;
    l = 8'b10101010;
    if (st == G) l[2*d +: 2] = 2'b00;
    else if (st == Y) l[2*d +: 2] = 2'b01;
    return l;
  endfunction

  task automatic pushExp(string tag, logic [1:0] st, logic [1:0] d);
    exp_t e;
    e.tag = tag;
    e.v   = {st, d, lightOf(st, d), (st == W)};
    sbq.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    logic [12:0] obs;
    obs = {bus.state_o, bus.cur_dir, bus.light, bus.walk};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b (state,dir,light,walk)", e.tag, obs, e.v);
      end
    end
  endtask

  // Called at a negedge; tick is seen by exactly one posedge.
  task automatic doTick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tk(string tag, logic [1:0] st, logic [1:0] d);
    pushExp(tag, st, d);
    doTick();
    popCheck();
  endtask

  task automatic pulseWalk();
    bus.walk_req = 1'b1;
    @(negedge clk);
    bus.walk_req = 1'b0;
  endtask

  task automatic doReset(logic [3:0] r);
    bus.req = r;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.req = 4'b0; bus.walk_req = 1'b0;
    bus.preempt = 1'b0; bus.preempt_dir = 2'd0;
    @(negedge clk);
    pushExp("reset_state", G, 2'd0);
    popCheck();
    reset = 1'b0;
    @(negedge clk);

    // Idle: no competing request rests on approach 0 green.
    for (int n = 0; n < 20; n++) tk("idle_rest", G, 2'd0);

    // Single side request.
    doReset(4'b0010);
    for (int n = 1; n <= 5; n++) tk("side_min_green", G, 2'd0);
    tk("side_yel6", Y, 2'd0);
    tk("side_yel7", Y, 2'd0);
    tk("side_allred", R, 2'd0);
    tk("side_green1", G, 2'd1);

    // Two approaches both demanding: max green alternation.
    doReset(4'b0011);
    for (int n = 1; n <= 11; n++) tk("alt_g0", G, 2'd0);
    tk("alt_y0a", Y, 2'd0);
    tk("alt_y0b", Y, 2'd0);
    tk("alt_r0", R, 2'd0);
    tk("alt_g1_entry", G, 2'd1);
    for (int n = 16; n <= 26; n++) tk("alt_g1", G, 2'd1);
    tk("alt_y1a", Y, 2'd1);
    tk("alt_y1b", Y, 2'd1);
    tk("alt_r1", R, 2'd1);
    tk("alt_wrap_g0", G, 2'd0);

    // Pedestrian phase, walk requests during WALK dropped, no back-to-back walk.
    doReset(4'b0000);
    tk("walk_t1", G, 2'd0);
    tk("walk_t2", G, 2'd0);
    pulseWalk();
    for (int n = 3; n <= 5; n++) tk("walk_g", G, 2'd0);
    tk("walk_y6", Y, 2'd0);
    tk("walk_y7", Y, 2'd0);
    tk("walk_r8", R, 2'd0);
    tk("walk_on9", W, 2'd0);
    pulseWalk();
    tk("walk_on10", W, 2'd0);
    tk("walk_on11", W, 2'd0);
    tk("walk_r12", R, 2'd0);
    pulseWalk();
    tk("walk_nobackto", G, 2'd0);
    for (int n = 14; n <= 18; n++) tk("walk_g2", G, 2'd0);
    tk("walk2_y", Y, 2'd0);
    tk("walk2_y", Y, 2'd0);
    tk("walk2_r", R, 2'd0);
    for (int n = 0; n < 3; n++) tk("walk2_on", W, 2'd0);
    tk("walk2_r_after", R, 2'd0);
    tk("walk2_g0", G, 2'd0);
    for (int n = 0; n < 8; n++) tk("walk_pend_clear", G, 2'd0);

    // Emergency preempt toward approach 2.
    doReset(4'b0000);
    tk("pre_t1", G, 2'd0);
    bus.preempt = 1'b1; bus.preempt_dir = 2'd2; bus.req = 4'b1011;
    pushExp("pre_yel_next_clk", Y, 2'd0);
    @(negedge clk);
    popCheck();
    tk("pre_yel_dwell", Y, 2'd0);
    tk("pre_allred", R, 2'd0);
    tk("pre_green2", G, 2'd2);
    for (int n = 0; n < 14; n++) tk("pre_hold", G, 2'd2);
    bus.preempt = 1'b0;
    tk("pre_release_yel", Y, 2'd2);

    // Preempt during WALK cuts straight to clearance.
    doReset(4'b0000);
    pulseWalk();
    for (int n = 1; n <= 5; n++) tk("pw_g", G, 2'd0);
    tk("pw_y", Y, 2'd0);
    tk("pw_y", Y, 2'd0);
    tk("pw_r", R, 2'd0);
    tk("pw_walk", W, 2'd0);
    bus.preempt = 1'b1; bus.preempt_dir = 2'd3;
    pushExp("pw_cut_allred", R, 2'd0);
    @(negedge clk);
    popCheck();
    tk("pw_green3", G, 2'd3);
    bus.preempt = 1'b0;

    // Asynchronous reset in WALK at timer=1.
    doReset(4'b0000);
    pulseWalk();
    for (int n = 1; n <= 5; n++) tk("ar_g", G, 2'd0);
    tk("ar_y", Y, 2'd0);
    tk("ar_y", Y, 2'd0);
    tk("ar_r", R, 2'd0);
    tk("ar_walk9", W, 2'd0);
    tk("ar_walk10", W, 2'd0);
    #2 reset = 1'b1;
    #1 pushExp("async_reset", G, 2'd0);
    popCheck();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 7; n++) tk("post_reset_rest", G, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
